alu_deco_seq: RTL and testbench

Registered, handshaked successor to the datapath ALU decoder in ControlUnit.
- Accepts one data-processing command per transfer: cmd[3:0], S bit, multiply flag.
- Produces a registered ALU control word, flag-write enables, register-write suppression and operand swap.
- Sequences multi-cycle multiplies with an internal counter; stalls upstream through in_ready.
- Sits between the instruction decoder and the execute-stage ALU.

---
 rtl/alu_deco_pkg.sv | 64 ++++++
 rtl/alu_deco_tbl.sv | 75 +++++++
 rtl/alu_deco_seq.sv | 127 ++++++++++++
 tb/tb_alu_deco_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_deco_pkg.sv
// alu_deco_pkg: shared opcodes, ALU control codes, FSM states and the decode
// payload used by the registered ALU decoder (alu_deco_seq) and its table.
package alu_deco_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned ALU_W = 4;
  localparam int unsigned FW_W  = 2;

  // Data-processing opcodes
  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_EOR = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_RSB = 4'b0011;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0100;
  localparam logic [OP_W-1:0] OP_ADC = 4'b0101;
  localparam logic [OP_W-1:0] OP_SBC = 4'b0110;
  localparam logic [OP_W-1:0] OP_RSC = 4'b0111;
  localparam logic [OP_W-1:0] OP_TST = 4'b1000;
  localparam logic [OP_W-1:0] OP_TEQ = 4'b1001;
  localparam logic [OP_W-1:0] OP_CMP = 4'b1010;
  localparam logic [OP_W-1:0] OP_CMN = 4'b1011;
  localparam logic [OP_W-1:0] OP_ORR = 4'b1100;
  localparam logic [OP_W-1:0] OP_MOV = 4'b1101;
  localparam logic [OP_W-1:0] OP_BIC = 4'b1110;
  localparam logic [OP_W-1:0] OP_MVN = 4'b1111;

  // ALU control codes
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_AND = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_ORR = 4'b1001;
  localparam logic [ALU_W-1:0] ALU_EOR = 4'b1010;
  localparam logic [ALU_W-1:0] ALU_MVN = 4'b1011;
  localparam logic [ALU_W-1:0] ALU_MOV = 4'b1100;
  localparam logic [ALU_W-1:0] ALU_MUL = 4'b1110;

  // Flag-write enables: bit 1 = NZ, bit 0 = CV
  localparam logic [FW_W-1:0] FW_NONE = 2'b00;
  localparam logic [FW_W-1:0] FW_NZ   = 2'b10;
  localparam logic [FW_W-1:0] FW_NZCV = 2'b11;

  // FSM state encodings
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_WAIT = 1'b1;

  typedef enum logic [0:0] {
    IDLE     = ST_IDLE,
    MUL_WAIT = ST_MUL_WAIT
  } state_t;

  typedef struct packed {
    logic [ALU_W-1:0] ctrl;
    logic [FW_W-1:0]  flag_write;
    logic             no_write;
    logic             swap_ab;
    logic             illegal;
  } deco_t;

  // Arithmetic ops update all four flags; logic ops only N and Z.
  function automatic logic [FW_W-1:0] class_flags(input logic arith);
    return arith ? FW_NZCV : FW_NZ;
  endfunction

endpackage

// File: rtl/alu_deco_tbl.sv
// alu_deco_tbl: purely combinational decode of one data-processing command.
// Ports:
//   cmd    - opcode (ignored when is_mul)
//   s_bit  - instruction S bit
//   is_mul - command is a multiply
//   deco   - control word, flag enables, write suppression, swap, illegal
// Optional: ALU_DECO_TRAP_EN flags ADC/SBC/RSC/BIC as illegal; otherwise they
// decode as ADD with arithmetic flag behaviour.
module alu_deco_tbl
  import alu_deco_pkg::*;
(
  input  logic [OP_W-1:0] cmd,
  input  logic            s_bit,
  input  logic            is_mul,
  output deco_t           deco
);

  logic [ALU_W-1:0] ctrl;
  logic             arith;
  logic             compare;
  logic             swap;
  logic             illegal;

  // Opcode -> control code and operation class
  always_comb begin
    ctrl    = ALU_ADD;
    arith   = 1'b1;
    compare = 1'b0;
    swap    = 1'b0;
    illegal = 1'b0;
    if (is_mul) begin
      ctrl  = ALU_MUL;
      arith = 1'b0;
    end else begin
      case (cmd)
        OP_AND: begin ctrl = ALU_AND; arith = 1'b0; end
        OP_EOR: begin ctrl = ALU_EOR; arith = 1'b0; end
        OP_SUB: ctrl = ALU_SUB;
        OP_RSB: begin ctrl = ALU_SUB; swap = 1'b1; end
        OP_ADD: ctrl = ALU_ADD;
        OP_TST: begin ctrl = ALU_AND; arith = 1'b0; compare = 1'b1; end
        OP_TEQ: begin ctrl = ALU_EOR; arith = 1'b0; compare = 1'b1; end
        OP_CMP: begin ctrl = ALU_SUB; compare = 1'b1; end
        OP_CMN: begin ctrl = ALU_ADD; compare = 1'b1; end
        OP_ORR: begin ctrl = ALU_ORR; arith = 1'b0; end
        OP_MOV: begin ctrl = ALU_MOV; arith = 1'b0; end
        OP_MVN: begin ctrl = ALU_MVN; arith = 1'b0; end
`ifdef ALU_DECO_TRAP_EN
        OP_ADC, OP_SBC, OP_RSC, OP_BIC: illegal = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // Flag enables and write suppression; compares ignore the S bit
  always_comb begin
    deco         = '0;
    deco.ctrl    = ctrl;
    deco.swap_ab = swap;
    deco.illegal = illegal;
    if (illegal) begin
      deco.ctrl       = ALU_ADD;
      deco.swap_ab    = 1'b0;
      deco.no_write   = 1'b1;
      deco.flag_write = FW_NONE;
    end else if (compare) begin
      deco.no_write   = 1'b1;
      deco.flag_write = class_flags(arith);
    end else if (s_bit) begin
      deco.flag_write = class_flags(arith);
    end
  end

endmodule

// File: rtl/alu_deco_seq.sv
// alu_deco_seq: registered, handshaked ALU decoder with multi-cycle MUL
// sequencing.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   in_valid/in_ready       - command handshake (cmd, s_bit, is_mul)
//   out_valid/out_ready     - result handshake
//   alu_control             - ALU op select, zero-extended to CTRL_W
//   flag_write              - [1] NZ enable, [0] CV enable
//   no_write                - suppress destination write
//   swap_ab                 - swap ALU operands
//   illegal_cmd             - only with ALU_DECO_TRAP_EN: trapped opcode
// Parameters: CTRL_W (>= 4), MUL_CYCLES (>= 1) accept-to-valid MUL latency.
module alu_deco_seq
  import alu_deco_pkg::*;
#(
  parameter int unsigned CTRL_W     = 4,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   cmd,
  input  logic              s_bit,
  input  logic              is_mul,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_control,
  output logic [FW_W-1:0]   flag_write,
  output logic              no_write,
  output logic              swap_ab
`ifdef ALU_DECO_TRAP_EN
  ,
  output logic              illegal_cmd
`endif
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  deco_t            tbl;
  deco_t            pend_q, pend_d;
  deco_t            res_q, res_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;

  alu_deco_tbl u_tbl (
    .cmd    (cmd),
    .s_bit  (s_bit),
    .is_mul (is_mul),
    .deco   (tbl)
  );

  // Accept only when idle and the result slot is empty or draining now
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state, counter and result-register selection
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    res_d       = res_q;
    out_valid_d = out_valid_q && !out_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul && (MUL_CYCLES > 1)) begin
            state_d = MUL_WAIT;
            cnt_d   = CNT_W'(1);
            pend_d  = tbl;
          end else begin
            res_d       = tbl;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          res_d       = pend_q;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_control = CTRL_W'(res_q.ctrl);
  assign flag_write  = res_q.flag_write;
  assign no_write    = res_q.no_write;
  assign swap_ab     = res_q.swap_ab;

`ifdef ALU_DECO_TRAP_EN
  assign illegal_cmd = res_q.illegal;
`else
  logic unused_illegal;
  assign unused_illegal = res_q.illegal;
`endif

endmodule

// File: tb/tb_alu_deco_seq.sv
// tb_alu_deco_seq: scoreboard bench for alu_deco_seq (CTRL_W=6, MUL_CYCLES=4).
module tb_alu_deco_seq;

  localparam int unsigned CTRL_W     = 6;
  localparam int unsigned MUL_CYCLES = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        cmd;
  logic              s_bit;
  logic              is_mul;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] alu_control;
  logic [1:0]        flag_write;
  logic              no_write;
  logic              swap_ab;
`ifdef ALU_DECO_TRAP_EN
  logic              illegal_cmd;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
`ifdef ALU_DECO_TRAP_EN
    logic       ill;
`endif
    logic [3:0] ctl;
    logic [1:0] fw;
    logic       nw;
    logic       sw;
  } exp_t;

  exp_t sb_q[$];

  alu_deco_seq #(.CTRL_W(CTRL_W), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cmd         (cmd),
    .s_bit       (s_bit),
    .is_mul      (is_mul),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_control (alu_control),
    .flag_write  (flag_write),
    .no_write    (no_write),
    .swap_ab     (swap_ab)
`ifdef ALU_DECO_TRAP_EN
    ,
    .illegal_cmd (illegal_cmd)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode written as a plain lookup: {ctrl, arith, compare, swap}
  function automatic exp_t model(input logic [3:0] c, input logic s, input logic m);
    exp_t e;
    logic [6:0] row;
    logic ill;
    ill = 1'b0;
    if (m) row = {4'b1110, 3'b000};
    else begin
      case (c)
        4'h0: row = {4'b1000, 3'b000};
        4'h1: row = {4'b1010, 3'b000};
        4'h2: row = {4'b0001, 3'b100};
        4'h3: row = {4'b0001, 3'b101};
        4'h4: row = {4'b0000, 3'b100};
        4'h8: row = {4'b1000, 3'b010};
        4'h9: row = {4'b1010, 3'b010};
        4'hA: row = {4'b0001, 3'b110};
        4'hB: row = {4'b0000, 3'b110};
        4'hC: row = {4'b1001, 3'b000};
        4'hD: row = {4'b1100, 3'b000};
        4'hF: row = {4'b1011, 3'b000};
        default: begin
          row = {4'b0000, 3'b100};
`ifdef ALU_DECO_TRAP_EN
          ill = 1'b1;
`endif
        end
      endcase
    end
    e.ctl = row[6:3];
    e.sw  = row[0];
    e.nw  = row[1] | ill;
    if (ill)                e.fw = 2'b00;
    else if (row[1] || s)   e.fw = row[2] ? 2'b11 : 2'b10;
    else                    e.fw = 2'b00;
    if (ill) e.ctl = 4'b0000;
`ifdef ALU_DECO_TRAP_EN
    e.ill = ill;
`endif
    return e;
  endfunction

  // Scoreboard: pop on output transfer, push on input accept; reset flushes
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_out", 32'(out_valid), 32'(0));
        end else begin
          e = sb_q.pop_front();
          check_eq("ctrl", 32'(alu_control), 32'(e.ctl));
          check_eq("flag_write", 32'(flag_write), 32'(e.fw));
          check_eq("no_write", 32'(no_write), 32'(e.nw));
          check_eq("swap_ab", 32'(swap_ab), 32'(e.sw));
`ifdef ALU_DECO_TRAP_EN
          check_eq("illegal", 32'(illegal_cmd), 32'(e.ill));
`endif
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(cmd, s_bit, is_mul));
    end
  end

  // Present one command; returns at posedge+1 of the accepting edge
  task automatic send(input logic [3:0] c, input logic s, input logic m);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    cmd = c;
    s_bit = s;
    is_mul = m;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check_eq("send_timeout", 32'(ok), 32'(1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    cmd = 4'h0;
    s_bit = 1'b0;
    is_mul = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_ctrl", 32'(alu_control), 32'(0));
    check_eq("rst_in_ready", 32'(in_ready), 32'(1));

    // Decode sweep, both S values, back-to-back with a draining consumer
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 16; c++) begin
        send(4'(c), 1'(s), 1'b0);
        check_eq("lat1_valid", 32'(out_valid), 32'(1));
      end
      send(4'h0, 1'(s), 1'b1);
    end

    // MUL latency: in_ready low for three cycles, result on the fourth
    repeat (2) tick();
    send(4'h5, 1'b1, 1'b1);
    for (int k = 1; k < 4; k++) begin
      #1;
      check_eq("mul_in_ready", 32'(in_ready), 32'(0));
      check_eq("mul_out_valid", 32'(out_valid), 32'(0));
      tick();
    end
    check_eq("mul_valid", 32'(out_valid), 32'(1));
    check_eq("mul_ctrl", 32'(alu_control), 32'(6'b001110));
    check_eq("mul_fw", 32'(flag_write), 32'(2'b10));

    // Reset two cycles into a MUL aborts it
    send(4'h0, 1'b0, 1'b1);
    tick();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("abort_in_ready", 32'(in_ready), 32'(1));
    check_eq("abort_ctrl", 32'(alu_control), 32'(0));
    check_eq("abort_fw", 32'(flag_write), 32'(0));
    check_eq("abort_nw", 32'(no_write), 32'(0));
    check_eq("abort_swap", 32'(swap_ab), 32'(0));
    for (int k = 0; k < 5; k++) begin
      check_eq("abort_no_valid", 32'(out_valid), 32'(0));
      tick();
    end

    // Backpressure: AND result held for 3 cycles with EOR waiting
    out_ready = 1'b0;
    send(4'h0, 1'b1, 1'b0);
    in_valid = 1'b1;
    cmd = 4'h1;
    s_bit = 1'b0;
    is_mul = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("hold_valid", 32'(out_valid), 32'(1));
      check_eq("hold_ctrl", 32'(alu_control), 32'(6'b001000));
      check_eq("hold_fw", 32'(flag_write), 32'(2'b10));
      check_eq("hold_in_ready", 32'(in_ready), 32'(0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_eq("drain_in_ready", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    check_eq("eor_valid", 32'(out_valid), 32'(1));
    check_eq("eor_ctrl", 32'(alu_control), 32'(6'b001010));

    // Trap opcode ADC
    tick();
    send(4'h5, 1'b1, 1'b0);
`ifdef ALU_DECO_TRAP_EN
    check_eq("trap_illegal", 32'(illegal_cmd), 32'(1));
    check_eq("trap_nw", 32'(no_write), 32'(1));
    check_eq("trap_fw", 32'(flag_write), 32'(0));
`else
    check_eq("adc_ctrl", 32'(alu_control), 32'(0));
    check_eq("adc_fw", 32'(flag_write), 32'(2'b11));
    check_eq("adc_nw", 32'(no_write), 32'(0));
`endif

    repeat (5) tick();
    check_eq("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
